// File: rtl/man_demod.sv
// Manchester line decoder: synchronizes the incoming line, times the gaps
// between edges and recovers one bit per mid-bit transition once locked.
module man_demod #(
  parameter int HALF_BIT = 4,
  parameter int TOL      = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_enable,
  input  logic in_data,
  output logic out_data,
  output logic out_valid,
  output logic out_error,
  output logic out_locked
);

  localparam int CNT_SAT = 2 * HALF_BIT + TOL + 1;
  localparam int CW      = $clog2(CNT_SAT + 1);

  localparam logic [CW-1:0] C_SAT      = CW'(CNT_SAT);
  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [CW-1:0] C_SHORT_LO = CW'(HALF_BIT - TOL);
  localparam logic [CW-1:0] C_SHORT_HI = CW'(HALF_BIT + TOL);
  localparam logic [CW-1:0] C_LONG_LO  = CW'(2 * HALF_BIT - TOL);
  localparam logic [CW-1:0] C_LONG_HI  = CW'(2 * HALF_BIT + TOL);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HUNT   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic          r_armed, w_armed_nxt;
  logic          r_bnd, w_bnd_nxt;
  logic          r_data, w_data_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_error, w_error_nxt;
  logic          r_sync1, r_sync2, r_sync3;
  logic          w_edge, w_short, w_long, w_sat;
  logic          w_emit, w_fail;

  // Two flops resolve metastability; the third only provides the previous
  // settled level so a transition shows up as a single-cycle edge strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= in_data;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_edge    = r_sync2 ^ r_sync3;
  assign w_sat     = (r_cnt == C_SAT);
  assign w_cnt_inc = w_sat ? r_cnt : r_cnt + C_ONE;
  assign w_short   = (r_cnt >= C_SHORT_LO) && (r_cnt <= C_SHORT_HI);
  assign w_long    = (r_cnt >= C_LONG_LO) && (r_cnt <= C_LONG_HI);

  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_inc;
    w_armed_nxt = r_armed;
    w_bnd_nxt   = r_bnd;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_error_nxt = 1'b0;
    w_emit      = 1'b0;
    w_fail      = 1'b0;

    if (!in_enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_armed_nxt = 1'b0;
      w_bnd_nxt   = 1'b0;
      w_data_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt = S_HUNT;
          w_cnt_nxt   = '0;
          w_armed_nxt = 1'b0;
          w_bnd_nxt   = 1'b0;
        end
        S_HUNT: begin
          w_bnd_nxt = 1'b0;
          if (w_edge) begin
            if (r_armed && w_long) begin
              w_emit = 1'b1;
            end else begin
              w_armed_nxt = 1'b1;
              w_cnt_nxt   = C_ONE;
            end
          end
        end
        S_LOCKED: begin
          // The counter keeps running across a bit-boundary edge so that the
          // next mid-bit edge is always timed against the previous one.
          if (w_edge) begin
            if (w_long) begin
              w_emit = 1'b1;
            end else if (w_short && !r_bnd) begin
              w_bnd_nxt = 1'b1;
            end else begin
              w_fail = 1'b1;
            end
          end else if (w_sat) begin
            w_fail = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase

      if (w_emit) begin
        w_state_nxt = S_LOCKED;
        w_cnt_nxt   = C_ONE;
        w_bnd_nxt   = 1'b0;
        w_armed_nxt = 1'b1;
        w_data_nxt  = r_sync2;
        w_valid_nxt = 1'b1;
      end

      if (w_fail) begin
        w_state_nxt = S_HUNT;
        w_cnt_nxt   = '0;
        w_bnd_nxt   = 1'b0;
        w_armed_nxt = 1'b0;
        w_error_nxt = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_armed <= 1'b0;
      r_bnd   <= 1'b0;
      r_data  <= 1'b0;
      r_valid <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_armed <= w_armed_nxt;
      r_bnd   <= w_bnd_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_error <= w_error_nxt;
    end
  end

  assign out_data   = r_data;
  assign out_valid  = r_valid;
  assign out_error  = r_error;
  assign out_locked = (r_state == S_LOCKED);

endmodule

// File: doc/man_demod.md
MAN_DEMOD -- requirements
Module: man_demod

Interface
REQ-001 Parameter HALF_BIT, default 4: nominal half-bit period in clk cycles; bit period is 2*HALF_BIT.
REQ-002 Parameter TOL, default 1: edge-timing tolerance in clk cycles; legal only if TOL >= 0, HALF_BIT-TOL >= 2 and 2*TOL < HALF_BIT.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_enable  input  1  decoder enable; 0 forces IDLE.
REQ-006 in_data  input  1  Manchester line from the encoder (man_mod out_data); asynchronous to clk.
REQ-007 out_data  output  1  last decoded bit, held until the next decode.
REQ-008 out_valid  output  1  one-cycle pulse: out_data updated this cycle.
REQ-009 out_error  output  1  one-cycle pulse: timing violation, lock lost.
REQ-010 out_locked  output  1  high while in LOCKED state.

Function
REQ-011 Line coding: bit 0 = high-then-low, bit 1 = low-then-high; the mid-bit transition carries the bit, and the decoded bit equals the line level after that transition.
REQ-012 in_data is passed through a 2-flop synchronizer plus one delay flop; edge = stage2 XOR stage3.
REQ-013 D = number of clk cycles between two consecutive detected edges; counter saturates at 2*HALF_BIT+TOL+1.
REQ-014 Windows: SHORT = [HALF_BIT-TOL, HALF_BIT+TOL]; LONG = [2*HALF_BIT-TOL, 2*HALF_BIT+TOL]; anything else = BAD.
REQ-015 States: IDLE, HUNT, LOCKED; in_enable=0 forces IDLE from any state on the next rising edge, clearing counter and flags.
REQ-016 IDLE -> HUNT when in_enable=1; all three pulse/level outputs stay 0 in IDLE.
REQ-017 HUNT: first edge arms the counter; each later edge with D in LONG is a mid-bit edge -> emit bit, go LOCKED; edge with D not in LONG re-arms the counter from that edge; no error pulses in HUNT.
REQ-018 LOCKED: counter measures D from last accepted mid-bit edge; edge with D in SHORT and boundary flag clear -> set boundary flag, no output.
REQ-019 LOCKED: edge with D in LONG -> emit bit, restart counter, clear boundary flag (regardless of boundary flag).
REQ-020 LOCKED: edge with D in BAD, second SHORT edge within one bit, or counter exceeding 2*HALF_BIT+TOL with no edge -> out_error=1 for one cycle, out_locked=0, go HUNT with counter disarmed.
REQ-021 Emit bit: out_data = synchronized line level after the edge, out_valid=1 for exactly one cycle, out_locked=1 from the same cycle.
REQ-022 Latency: out_valid and out_data register on the 2nd clk rising edge after the edge at which the in_data transition is first sampled.
REQ-023 out_valid and out_error never assert in the same cycle.
REQ-024 out_data holds its last value through HUNT and error; it clears only on reset or IDLE.

Reset
REQ-025 rst_n=0 asynchronously sets state IDLE, counter 0, flags 0, synchronizer flops 0, and out_data, out_valid, out_error, out_locked to 0.
REQ-026 Reset asserted mid-frame discards the partial bit; after release the decoder must reacquire lock through HUNT.
REQ-027 Release of rst_n is synchronous in effect; first state change occurs on the first rising clk edge with rst_n=1.

Verification (HALF_BIT=4, TOL=1)
REQ-028 Reset: pulse rst_n low mid-stream while LOCKED -> all outputs 0 immediately, without waiting for a clk edge; no out_valid until relock.
REQ-029 Lock and decode: in_enable=1, send bits 0,1,0,1,1,0 at 8 cycles/bit -> first LONG gap (0->1) locks; out_valid pulses every 8 cycles thereafter with out_data 1,0,1,1,0; out_locked=1 after the first pulse.
REQ-030 Jitter: in LOCKED, edge intervals of 3/5 (SHORT) and 7/9 (LONG) are accepted with no error; an interval of 6 -> out_error pulse, out_locked=0, state HUNT.
REQ-031 Stuck line: hold in_data constant for 12 cycles in LOCKED -> out_error pulse when counter passes 9; no out_valid.
REQ-032 No lock on repeated bits: stream of all 1s (only SHORT intervals) -> out_locked stays 0, no out_valid, no out_error.
REQ-033 Enable drop: deassert in_enable mid-bit -> next cycle IDLE, out_locked=0, out_data=0; reassert -> HUNT, relock on next LONG gap.
